// File: rtl/ikaopll_dac_mixer_pkg.sv
// ----------------------------------------------------------------------------
// IKAOPLL_dac_pkg
// Shared defaults for the OPLL DAC mixer plus the saturation helpers used by
// each channel accumulator.
//   DATA_W_DEF / VOL_W_DEF / OUT_W_DEF / ACC_W_DEF : default datapath widths
//   FRAME_LEN_DEF / CYC0_DLY_DEF / STRB_LEN_DEF    : default frame timing
//   sat_value()   : clamp a wide signed value into an out_w-bit signed range
//   sat_clipped() : 1 when sat_value() had to clamp
// ----------------------------------------------------------------------------
package IKAOPLL_dac_pkg;

    localparam int DATA_W_DEF    = 9;
    localparam int VOL_W_DEF     = 5;
    localparam int OUT_W_DEF     = 16;
    localparam int ACC_W_DEF     = 20;
    localparam int FRAME_LEN_DEF = 18;
    localparam int CYC0_DLY_DEF  = 3;
    localparam int STRB_LEN_DEF  = 9;

    // Saturation is done at a fixed generous width so the helpers stay usable
    // for any accumulator/output width combination up to 64 bits.
    localparam int SAT_CALC_W = 64;
    typedef logic signed [SAT_CALC_W-1:0] wide_t;

    function automatic wide_t sat_hi(input int out_w);
        return (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_value(input wide_t x, input int out_w);
        wide_t hi;
        wide_t lo;
        hi = sat_hi(out_w);
        lo = -hi - wide_t'(1);
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic logic sat_clipped(input wide_t x, input int out_w);
        wide_t hi;
        wide_t lo;
        hi = sat_hi(out_w);
        lo = -hi - wide_t'(1);
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/ikaopll_dac_mixer_satacc.sv
// ----------------------------------------------------------------------------
// IKAOPLL_dac_satacc
// One output channel: accumulates signed products over a frame, and on the
// frame boundary publishes the saturated sum plus a clip flag, then clears.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_tick     : clock enable; nothing changes without it
//   i_bound    : this tick is a frame boundary (publish + clear, no add)
//   i_add      : accumulate i_prod on a non-boundary tick
//   i_prod     : signed product to add
//   o_sat      : saturated frame sum, held between boundaries
//   o_clip     : 1 when the published sum was clamped
// ----------------------------------------------------------------------------
module IKAOPLL_dac_satacc
    import IKAOPLL_dac_pkg::*;
#(
    parameter int PROD_W = 14,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_tick,
    input  logic                     i_bound,
    input  logic                     i_add,
    input  logic signed [PROD_W-1:0] i_prod,
    output logic signed [OUT_W-1:0]  o_sat,
    output logic                     o_clip
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] sat_q, sat_d;
    logic                    clip_q, clip_d;
    wide_t                   acc_wide;
    wide_t                   sat_wide;

    always_comb begin
        acc_wide = wide_t'(acc_q);
        sat_wide = sat_value(acc_wide, OUT_W);
        acc_d    = acc_q;
        sat_d    = sat_q;
        clip_d   = clip_q;
        if (i_tick) begin
            // The boundary slot is dropped: publish the pre-clear sum only.
            if (i_bound) begin
                acc_d  = '0;
                sat_d  = sat_wide[OUT_W-1:0];
                clip_d = sat_clipped(acc_wide, OUT_W);
            end else if (i_add) begin
                acc_d = acc_q + ACC_W'(i_prod);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sat_q  <= '0;
            clip_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            sat_q  <= sat_d;
            clip_q <= clip_d;
        end
    end

    assign o_sat  = sat_q;
    assign o_clip = clip_q;

endmodule

// File: rtl/ikaopll_dac_mixer.sv
// ----------------------------------------------------------------------------
// ikaopll_dac_mixer
// Frame-based stereo mixer for the OPLL sample stream. Each valid slot is
// scaled by the melody or rhythm volume and added into the panned channels;
// at the delayed frame marker the sums are saturated and published with a
// valid/ready handshake, overrun flag and a fixed-width strobe.
//   i_EMUCLK, i_RST_n      : clock and asynchronous active-low reset
//   i_phi1_NCEN_n          : active-low tick enable
//   i_CYCLE_00             : frame-start marker (delayed CYC0_DLY ticks)
//   i_SAMPLE_*             : sign-magnitude sample and its valid flag
//   i_IS_RHYTHM, i_PAN     : volume select and left/right routing
//   i_MOVOL, i_ROVOL       : signed melody / rhythm volumes
//   o_L, o_R, o_CLIP_*     : published saturated frame sums and clip flags
//   o_VALID, i_READY       : output handshake (ready honoured on any edge)
//   o_OVERRUN, i_CLR_OVERRUN : sticky unread-frame-overwritten flag
//   o_STRB                 : strobe high STRB_LEN ticks, 2 ticks after B
// ----------------------------------------------------------------------------
module ikaopll_dac_mixer
    import IKAOPLL_dac_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int VOL_W     = VOL_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CYC0_DLY  = CYC0_DLY_DEF,
    parameter int STRB_LEN  = STRB_LEN_DEF
) (
    input  logic                    i_EMUCLK,
    input  logic                    i_RST_n,
    input  logic                    i_phi1_NCEN_n,
    input  logic                    i_CYCLE_00,
    input  logic                    i_SAMPLE_VALID,
    input  logic                    i_SAMPLE_SIGN,
    input  logic [DATA_W-2:0]       i_SAMPLE_MAG,
    input  logic                    i_IS_RHYTHM,
    input  logic [1:0]              i_PAN,
    input  logic signed [VOL_W-1:0] i_MOVOL,
    input  logic signed [VOL_W-1:0] i_ROVOL,
    output logic signed [OUT_W-1:0] o_L,
    output logic signed [OUT_W-1:0] o_R,
    output logic                    o_VALID,
    input  logic                    i_READY,
    output logic                    o_STRB,
    output logic                    o_CLIP_L,
    output logic                    o_CLIP_R,
    output logic                    o_OVERRUN,
    input  logic                    i_CLR_OVERRUN
);

    localparam int PROD_W = DATA_W + VOL_W;
    // Wide enough that the all-ones reset value never equals 1 or 1+STRB_LEN.
    localparam int CNT_W  = $clog2(STRB_LEN + 3);

    generate
        if (ACC_W < DATA_W + VOL_W + $clog2(FRAME_LEN)) begin : g_acc_w_check
            $error("ikaopll_dac_mixer: ACC_W too small for a full frame");
        end
    endgenerate

    logic                     tick;
    logic                     bound;
    logic                     b_tick;
    logic [CYC0_DLY-1:0]      dly_q, dly_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     strb_q, strb_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic signed [DATA_W-1:0] sample_val;
    logic signed [VOL_W-1:0]  vol;
    logic signed [PROD_W-1:0] prod;

    assign tick   = ~i_phi1_NCEN_n;
    assign bound  = dly_q[CYC0_DLY-1];
    assign b_tick = tick & bound;

    // -(MAG+1) is exactly the bitwise inverse of the zero-extended magnitude.
    assign sample_val = i_SAMPLE_SIGN ? ~{1'b0, i_SAMPLE_MAG} : {1'b0, i_SAMPLE_MAG};
    assign vol        = i_IS_RHYTHM ? i_ROVOL : i_MOVOL;
    assign prod       = PROD_W'(sample_val) * PROD_W'(vol);

    always_comb begin
        dly_d = dly_q;
        if (tick) begin
            dly_d[0] = i_CYCLE_00;
            for (int i = 1; i < CYC0_DLY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    // Position counter and strobe: counter saturates so a missing frame
    // marker can never retrigger the strobe.
    always_comb begin
        cnt_d  = cnt_q;
        strb_d = strb_q;
        if (tick) begin
            if (bound) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == CNT_W'(1)) begin
                strb_d = 1'b1;
            end else if (cnt_q == CNT_W'(1 + STRB_LEN)) begin
                strb_d = 1'b0;
            end
        end
    end

    // Handshake runs on every edge; a boundary publish always wins over a
    // concurrent accept, and an overrun set wins over a concurrent clear.
    always_comb begin
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (b_tick) begin
            valid_d = 1'b1;
        end else if (valid_q && i_READY) begin
            valid_d = 1'b0;
        end
        if (b_tick && valid_q && !i_READY) begin
            overrun_d = 1'b1;
        end else if (i_CLR_OVERRUN) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            dly_q     <= '0;
            cnt_q     <= '1;
            strb_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dly_q     <= dly_d;
            cnt_q     <= cnt_d;
            strb_q    <= strb_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    IKAOPLL_dac_satacc #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_acc_l (
        .clk     (i_EMUCLK),
        .rst_n   (i_RST_n),
        .i_tick  (tick),
        .i_bound (bound),
        .i_add   (i_SAMPLE_VALID & i_PAN[0]),
        .i_prod  (prod),
        .o_sat   (o_L),
        .o_clip  (o_CLIP_L)
    );

    IKAOPLL_dac_satacc #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_acc_r (
        .clk     (i_EMUCLK),
        .rst_n   (i_RST_n),
        .i_tick  (tick),
        .i_bound (bound),
        .i_add   (i_SAMPLE_VALID & i_PAN[1]),
        .i_prod  (prod),
        .o_sat   (o_R),
        .o_clip  (o_CLIP_R)
    );

    assign o_STRB    = strb_q;
    assign o_VALID   = valid_q;
    assign o_OVERRUN = overrun_q;

endmodule

// File: tb/tb_ikaopll_dac_mixer.sv
// ----------------------------------------------------------------------------
// tb_ikaopll_dac_mixer
// Directed bench for the DAC mixer: a table of whole frames with hand-computed
// sums, then hand-written sequences for overrun, handshake on the boundary
// edge, mid-frame reset and the strobe window.
// ----------------------------------------------------------------------------
module tb_ikaopll_dac_mixer;

    localparam int DATA_W   = 9;
    localparam int VOL_W    = 5;
    localparam int OUT_W    = 16;
    localparam int CYC0_DLY = 3;

    typedef struct {
        logic                    sign;
        logic [DATA_W-2:0]       mag;
        logic                    rhythm;
        logic [1:0]              pan;
        logic signed [VOL_W-1:0] movol;
        logic signed [VOL_W-1:0] rovol;
        int                      n;
        int                      exp_l;
        int                      exp_r;
        logic                    clip_l;
        logic                    clip_r;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    ncen_n;
    logic                    cycle_00;
    logic                    sample_valid;
    logic                    sample_sign;
    logic [DATA_W-2:0]       sample_mag;
    logic                    is_rhythm;
    logic [1:0]              pan;
    logic signed [VOL_W-1:0] movol;
    logic signed [VOL_W-1:0] rovol;
    logic signed [OUT_W-1:0] out_l;
    logic signed [OUT_W-1:0] out_r;
    logic                    out_valid;
    logic                    ready;
    logic                    strb;
    logic                    clip_l;
    logic                    clip_r;
    logic                    overrun;
    logic                    clr_overrun;

    int   n_checks = 0;
    int   n_errors = 0;
    logic strb_seen;
    vec_t vecs[8];
    vec_t idle_v;
    vec_t tmp_v;

    ikaopll_dac_mixer dut (
        .i_EMUCLK       (clk),
        .i_RST_n        (rst_n),
        .i_phi1_NCEN_n  (ncen_n),
        .i_CYCLE_00     (cycle_00),
        .i_SAMPLE_VALID (sample_valid),
        .i_SAMPLE_SIGN  (sample_sign),
        .i_SAMPLE_MAG   (sample_mag),
        .i_IS_RHYTHM    (is_rhythm),
        .i_PAN          (pan),
        .i_MOVOL        (movol),
        .i_ROVOL        (rovol),
        .o_L            (out_l),
        .o_R            (out_r),
        .o_VALID        (out_valid),
        .i_READY        (ready),
        .o_STRB         (strb),
        .o_CLIP_L       (clip_l),
        .o_CLIP_R       (clip_r),
        .o_OVERRUN      (overrun),
        .i_CLR_OVERRUN  (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one edge worth of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input vec_t v, input logic valid, input logic cyc0,
                                 input logic ncen, input logic rdy, input logic clr);
        sample_sign  = v.sign;
        sample_mag   = v.mag;
        is_rhythm    = v.rhythm;
        pan          = v.pan;
        movol        = v.movol;
        rovol        = v.rovol;
        sample_valid = valid;
        cycle_00     = cyc0;
        ncen_n       = ncen;
        ready        = rdy;
        clr_overrun  = clr;
        @(posedge clk);
        #1;
    endtask

    // v.n valid ticks, marker timed so the next tick is the boundary, then
    // the boundary tick itself (still carrying a valid sample that must be
    // dropped). A non-tick edge with a different sample is slipped in.
    task automatic run_frame(input vec_t v, input logic ready_on_b, input logic clr_on_b);
        vec_t junk;
        junk      = v;
        junk.sign = 1'b0;
        junk.mag  = '1;
        for (int i = 0; i < v.n; i++) begin
            if (i == 2) applyStimulus(junk, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            applyStimulus(v, 1'b1, (i == v.n - CYC0_DLY), 1'b0, 1'b0, 1'b0);
            strb_seen = strb_seen | strb;
        end
        applyStimulus(v, 1'b1, 1'b0, 1'b0, ready_on_b, clr_on_b);
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        checkOutput({tag, "_L"}, out_l, v.exp_l);
        checkOutput({tag, "_R"}, out_r, v.exp_r);
        checkOutput({tag, "_clipL"}, clip_l, v.clip_l);
        checkOutput({tag, "_clipR"}, clip_r, v.clip_r);
        checkOutput({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_L"}, out_l, 0);
        checkOutput({tag, "_R"}, out_r, 0);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_strb"}, strb, 0);
        checkOutput({tag, "_clipL"}, clip_l, 0);
        checkOutput({tag, "_clipR"}, clip_r, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
    endtask

    // Strobe must rise on the 2nd tick after the boundary, stay 9 ticks,
    // and never return while the counter sits saturated.
    task automatic check_strb_window(input string tag);
        for (int k = 1; k <= 25; k++) begin
            applyStimulus(idle_v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("%s_strb_k%0d", tag, k), strb, (k >= 2 && k <= 10) ? 1 : 0);
        end
    endtask

    function automatic vec_t mk(input logic sg, input int mg, input logic rh, input logic [1:0] pn,
                                input int mv, input int rv, input int n, input int el,
                                input int er, input logic cl, input logic cr);
        vec_t v;
        v.sign   = sg;
        v.mag    = mg[DATA_W-2:0];
        v.rhythm = rh;
        v.pan    = pn;
        v.movol  = mv[VOL_W-1:0];
        v.rovol  = rv[VOL_W-1:0];
        v.n      = n;
        v.exp_l  = el;
        v.exp_r  = er;
        v.clip_l = cl;
        v.clip_r = cr;
        return v;
    endfunction

    initial begin
        idle_v    = mk(1'b0, 0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        strb_seen = 1'b0;

        //            sign  mag  rhy  pan    mv   rv  n   expL    expR    clipL clipR
        vecs[0] = mk(1'b0, 100, 1'b0, 2'b11,   4,  0, 18,   7200,   7200, 1'b0, 1'b0);
        vecs[1] = mk(1'b1,   0, 1'b1, 2'b01,   7,  1, 18,    -18,      0, 1'b0, 1'b0);
        vecs[2] = mk(1'b0, 255, 1'b0, 2'b01,  15,  0, 18,  32767,      0, 1'b1, 1'b0);
        vecs[3] = mk(1'b1, 255, 1'b0, 2'b01,  15,  0, 18, -32768,      0, 1'b1, 1'b0);
        vecs[4] = mk(1'b0,  10, 1'b0, 2'b10,  -3,  0, 18,      0,   -540, 1'b0, 1'b0);
        vecs[5] = mk(1'b1,   9, 1'b0, 2'b11, -16,  7, 18,   2880,   2880, 1'b0, 1'b0);
        vecs[6] = mk(1'b0, 255, 1'b0, 2'b10, -16,  0, 18,      0, -32768, 1'b0, 1'b1);
        vecs[7] = mk(1'b0,   7, 1'b0, 2'b11,   2,  0,  5,     70,     70, 1'b0, 1'b0);

        rst_n = 1'b0;
        applyStimulus(idle_v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(idle_v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_all_zero("reset");
        #3 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i], 1'b0, 1'b0);
            check_frame($sformatf("vec%0d", i), vecs[i]);
            checkOutput($sformatf("vec%0d_overrun", i), overrun, 0);
            // Accept on a non-tick edge: handshake must still respond.
            applyStimulus(idle_v, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("vec%0d_accept", i), out_valid, 0);
        end

        // Two frames without acceptance: second overwrites and flags overrun.
        run_frame(vecs[0], 1'b0, 1'b0);
        tmp_v = mk(1'b0, 1, 1'b0, 2'b11, 1, 0, 18, 18, 18, 1'b0, 1'b0);
        run_frame(tmp_v, 1'b0, 1'b0);
        check_frame("ovr", tmp_v);
        checkOutput("ovr_flag", overrun, 1);
        applyStimulus(idle_v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("ovr_cleared", overrun, 0);
        checkOutput("ovr_clear_keeps_valid", out_valid, 1);

        // Ready on the boundary edge itself: new data, still valid, no overrun.
        tmp_v = mk(1'b0, 2, 1'b0, 2'b01, 1, 0, 18, 36, 0, 1'b0, 1'b0);
        run_frame(tmp_v, 1'b1, 1'b0);
        check_frame("rdyb", tmp_v);
        checkOutput("rdyb_overrun", overrun, 0);

        // Overrun set and clear on the same edge: set wins.
        tmp_v = mk(1'b0, 3, 1'b0, 2'b01, 1, 0, 18, 54, 0, 1'b0, 1'b0);
        run_frame(tmp_v, 1'b0, 1'b1);
        check_frame("setwin", tmp_v);
        checkOutput("setwin_overrun", overrun, 1);
        applyStimulus(idle_v, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("setwin_valid_acc", out_valid, 0);
        checkOutput("setwin_ovr_clr", overrun, 0);

        // Reset in the middle of a frame while the strobe is high.
        tmp_v = mk(1'b0, 5, 1'b0, 2'b11, 1, 0, 18, 90, 90, 1'b0, 1'b0);
        run_frame(tmp_v, 1'b0, 1'b0);
        check_frame("prerst", tmp_v);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(vecs[0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("prerst_strb", strb, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        applyStimulus(vecs[0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_held_valid", out_valid, 0);
        #3 rst_n = 1'b1;
        strb_seen = 1'b0;
        run_frame(vecs[0], 1'b0, 1'b0);
        checkOutput("postrst_no_strb", strb_seen, 0);
        check_frame("postrst", vecs[0]);
        check_strb_window("postrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
